// File: rtl/muldiv_pkg.sv
// Shared opcode, state and operand-signedness definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step on magnitudes.
module muldiv_step #(
    parameter int Width = 32
) (
    input  logic             div_mode,
    input  logic [Width-1:0] hi_in,
    input  logic [Width-1:0] lo_in,
    input  logic [Width-1:0] operand,
    output logic [Width-1:0] hi_out,
    output logic [Width-1:0] lo_out,
    output logic             q_bit
);

    logic [Width:0]   sum;
    logic [Width+1:0] trial;

    always_comb begin
        sum   = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : {(Width+1){1'b0}});
        // Two guard bits so the borrow is exact even for a zero divisor.
        trial = {1'b0, hi_in, lo_in[Width-1]} - {2'b00, operand};
        q_bit = div_mode & ~trial[Width+1];
        if (div_mode) begin
            hi_out = q_bit ? trial[Width-1:0] : {hi_in[Width-2:0], lo_in[Width-1]};
        end else begin
            hi_out = sum[Width:1];
        end
        lo_out = {sum[0], lo_in[Width-1:1]};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: 33 cycles accept-to-Done (2 with MULDIV_EARLY_OUT_EN for trivial cases).
// Start is accepted only while Busy=0; requests during Busy are dropped, not queued.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int Width = 32,
    parameter int CntW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [Width-1:0] OperandA,
    input  logic [Width-1:0] OperandB,
    input  logic [4:0]       DestReg,
    output logic             Busy,
    output logic             Done,
    output logic [Width-1:0] Result,
    output logic [4:0]       ResultReg
);

    state_t            state, state_nxt;
    logic [CntW-1:0]   cnt;
    logic [2:0]        op_q;
    logic              neg_q, early_q;
    logic [4:0]        rd_q;
    logic [Width-1:0]  hi, lo, opnd, hi_d, lo_d;
    logic [Width-1:0]  step_hi, step_lo;
    logic              step_q;
    logic              neg_a, neg_b, b_zero, early_det, ld_neg;
    logic [Width-1:0]  mag_a, mag_b, ld_hi, ld_lo, ld_opnd;
`ifdef MULDIV_EARLY_OUT_EN
    logic              ovf;
`endif

    // Final sign fix-up applied to the magnitude result.
    function automatic logic [Width-1:0] finalize(input logic [2:0] op, input logic neg,
                                                  input logic [Width-1:0] h, input logic [Width-1:0] l);
        logic [2*Width-1:0] p;
        logic [Width-1:0]   r;
        p = {h, l};
        if (neg) p = -p;
        if (op[2]) begin
            r = op[1] ? h : l;
            if (neg) r = -r;
        end else if (op == OP_MUL) begin
            r = p[Width-1:0];
        end else begin
            r = p[2*Width-1:Width];
        end
        return r;
    endfunction

    always_comb begin
        neg_a   = is_signed_a(Op) & OperandA[Width-1];
        neg_b   = is_signed_b(Op) & OperandB[Width-1];
        mag_a   = neg_a ? -OperandA : OperandA;
        mag_b   = neg_b ? -OperandB : OperandB;
        b_zero  = (OperandB == '0);
        ld_hi   = '0;
        if (is_div(Op)) begin
            ld_lo   = mag_a;
            ld_opnd = mag_b;
            ld_neg  = Op[1] ? neg_a : ((neg_a ^ neg_b) & ~b_zero);
        end else begin
            ld_lo   = mag_b;
            ld_opnd = mag_a;
            ld_neg  = neg_a ^ neg_b;
        end
`ifdef MULDIV_EARLY_OUT_EN
        ovf = ((Op == OP_DIV) || (Op == OP_REM)) && (OperandA == {1'b1, {(Width-1){1'b0}}})
              && (OperandB == '1);
        early_det = is_div(Op) ? (b_zero | ovf) : ((OperandA == '0) || b_zero);
        // Preload exactly what the full iteration would leave in hi/lo.
        if (early_det) begin
            if (!is_div(Op)) begin
                ld_lo = '0;
            end else if (b_zero) begin
                ld_hi = mag_a;
                ld_lo = '1;
            end
        end
`else
        early_det = 1'b0;
`endif
    end

    muldiv_step #(.Width(Width)) u_step (
        .div_mode (op_q[2]),
        .hi_in    (hi),
        .lo_in    (lo),
        .operand  (opnd),
        .hi_out   (step_hi),
        .lo_out   (step_lo),
        .q_bit    (step_q)
    );

    always_comb begin
        hi_d = hi;
        lo_d = lo;
        if (state == ST_IDLE && Start) begin
            hi_d = ld_hi;
            lo_d = ld_lo;
        end else if (state == ST_CALC && !early_q) begin
            hi_d = step_hi;
            lo_d = op_q[2] ? {lo[Width-2:0], step_q} : step_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (Start) state_nxt = ST_CALC;
            ST_CALC:   if (early_q || cnt == CntW'(Width-1)) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state != ST_IDLE);
        Done = (state == ST_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            early_q   <= 1'b0;
            rd_q      <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            Result    <= '0;
            ResultReg <= '0;
        end else begin
            hi <= hi_d;
            lo <= lo_d;
            if (state == ST_IDLE && Start) begin
                op_q    <= Op;
                neg_q   <= ld_neg;
                early_q <= early_det;
                rd_q    <= DestReg;
                opnd    <= ld_opnd;
                cnt     <= '0;
            end else if (state == ST_CALC) begin
                cnt <= (state_nxt == ST_FINISH) ? '0 : cnt + CntW'(1);
            end
            if (state == ST_CALC && state_nxt == ST_FINISH) begin
                Result    <= finalize(op_q, neg_q, hi_d, lo_d);
                ResultReg <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: fixed vectors, special cases, ignored starts, mid-op reset, random back-to-back.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = '0;
    logic [31:0] OperandA = '0;
    logic [31:0] OperandB = '0;
    logic [4:0]  DestReg = '0;
    logic        Busy, Done;
    logic [31:0] Result;
    logic [4:0]  ResultReg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;
    exp_t scb[$];

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EarlyEn = 1'b1;
`else
    localparam bit EarlyEn = 1'b0;
`endif

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .DestReg   (DestReg),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .ResultReg (ResultReg)
    );

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(sa * sbv); return p[31:0];  end
            3'd1: begin p = 64'(sa * sbv); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub);  return p[63:32]; end
            3'd3: begin p = 64'(ua * ub);  return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic trivial;
        if (op[2]) trivial = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else       trivial = (a == 0) || (b == 0);
        return (EarlyEn && trivial) ? 2 : 33;
    endfunction

    // Called at a negedge; returns at the negedge after the unit is idle again.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res);
        exp_t e, got;
        int   cyc, bcnt;
        e.res = exp_res;
        e.rd  = rd;
        e.lat = exp_lat(op, a, b);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b; DestReg = rd;
        scb.push_back(e);
        @(negedge clk);
        Start = 1'b0; Op = 3'($urandom); OperandA = $urandom; OperandB = $urandom; DestReg = 5'($urandom);
        cyc = 1; bcnt = 0;
        while (!Done && cyc < 100) begin
            if (Busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        got = scb.pop_front();
        checks++;
        if (!Done) begin
            errors++;
            $display("FAIL %s timeout: no Done within %0d cycles", name, cyc);
            return;
        end
        checks++;
        if (Result !== got.res) begin
            errors++; $display("FAIL %s result: got %h expected %h", name, Result, got.res);
        end
        checks++;
        if (ResultReg !== got.rd) begin
            errors++; $display("FAIL %s result_reg: got %0d expected %0d", name, ResultReg, got.rd);
        end
        checks++;
        if (cyc != got.lat) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, got.lat);
        end
        checks++;
        if (bcnt + (Busy ? 1 : 0) != got.lat) begin
            errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt + (Busy ? 1 : 0), got.lat);
        end
        @(negedge clk);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL %s after_done: got busy=%b done=%b expected 0 0", name, Busy, Done);
        end
        checks++;
        if (Result !== got.res) begin
            errors++; $display("FAIL %s hold: got %h expected %h", name, Result, got.res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'h0 || ResultReg !== 5'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h rd=%0d expected all 0", Busy, Done, Result, ResultReg);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: got busy=%b expected 0", Busy);
        end
    endtask

    task automatic test_mul();
        run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF);
        run_op("mul_zero", 3'd1, 32'h0,       32'hDEAD_BEEF, 5'd9,  32'h0);
    endtask

    task automatic test_div();
        run_op("divu", 3'd5, 32'd100,       32'd7, 5'd10, 32'd14);
        run_op("remu", 3'd7, 32'd100,       32'd7, 5'd11, 32'd2);
        run_op("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD);
        run_op("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd0,  32'hFFFF_FFFF);
    endtask

    task automatic test_special();
        run_op("div_by0",  3'd4, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF);
        run_op("rem_by0",  3'd6, 32'd5,         32'd0,         5'd14, 32'd5);
        run_op("remu_by0", 3'd7, 32'hF000_0001, 32'd0,         5'd15, 32'hF000_0001);
        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
        run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0);
    endtask

    task automatic test_ignored_start();
        exp_t e, got;
        int   cyc, ndone, done_cyc;
        logic [31:0] first_res;
        logic [4:0]  first_rd;
        logic        busy_after;
        e.res = 32'd333; e.rd = 5'd9; e.lat = 33;
        Start = 1'b1; Op = 3'd5; OperandA = 32'd1000; OperandB = 32'd3; DestReg = 5'd9;
        scb.push_back(e);
        @(negedge clk);
        cyc = 1; ndone = 0; done_cyc = 0; first_res = '0; first_rd = '0; busy_after = 1'b1;
        while (cyc < 45) begin
            Start = (cyc == 3 || cyc == 10);
            Op = 3'd0; OperandA = 32'd5; OperandB = 32'd6; DestReg = 5'd1;
            if (done_cyc != 0 && cyc == done_cyc + 1) busy_after = Busy;
            if (Done) begin
                ndone++;
                if (ndone == 1) begin
                    first_res = Result; first_rd = ResultReg; done_cyc = cyc;
                end
                Start = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        Start = 1'b0;
        got = scb.pop_front();
        checks++;
        if (ndone != 1) begin
            errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone);
        end
        checks++;
        if (first_res !== got.res || first_rd !== got.rd) begin
            errors++; $display("FAIL ignore_result: got %h/%0d expected %h/%0d", first_res, first_rd, got.res, got.rd);
        end
        checks++;
        if (done_cyc != got.lat) begin
            errors++; $display("FAIL ignore_latency: got %0d expected %0d", done_cyc, got.lat);
        end
        checks++;
        if (busy_after !== 1'b0) begin
            errors++; $display("FAIL ignore_finish_start: got busy=%b expected 0", busy_after);
        end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        int   ndone;
        e.res = ref_model(3'd4, 32'd1000, 32'hFFFF_FFF9); e.rd = 5'd12; e.lat = 33;
        Start = 1'b1; Op = 3'd4; OperandA = 32'd1000; OperandB = 32'hFFFF_FFF9; DestReg = 5'd12;
        scb.push_back(e);
        @(negedge clk);
        Start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'h0 || ResultReg !== 5'h0) begin
            errors++;
            $display("FAIL midop_reset: got busy=%b done=%b result=%h rd=%0d expected all 0", Busy, Done, Result, ResultReg);
        end
        e = scb.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL midop_no_done: got %0d Done pulses expected 0", ndone);
        end
        run_op("mul_after_reset", 3'd0, 32'd3, 32'd4, 5'd3, 32'd12);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i == 4) a = 32'h8000_0001;
            run_op("random", op, a, b, 5'($urandom), ref_model(op, a, b));
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_ignored_start();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution stage for the RISC-V CPU.
- Sits directly downstream of the register file. It consumes the two register read-data values and the destination register number.
- Produces a result and register number for the register-file write port, with a Busy/Done handshake so the control path can stall the PC while an operation runs.
- Uses one shift/add or shift/subtract step per cycle: a full 32-step unit, not a single-cycle array.

Parameters:
- Width, 32, operand/result width in bits; only 32 is verified.
- CntW, 5, iteration counter width; equals clog2(Width).

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- Start  input  1  request pulse; sampled only when Busy=0.
- Op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- OperandA  input  Width  rs1 value (register-file ReadData1).
- OperandB  input  Width  rs2 value (register-file ReadData2).
- DestReg  input  5  rd number.
- Busy  output  1  high while an operation is in progress, including the Done cycle.
- Done  output  1  one-cycle pulse; Result and ResultReg are valid in this cycle.
- Result  output  Width  operation result.
- ResultReg  output  5  latched rd; drives register-file WriteReg, with Done driving RegWrite.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; Busy=0, Done=0, Result=0, ResultReg=0, counter=0.
  - An operation in flight is abandoned and never produces Done.
- States: IDLE -> CALC -> FINISH -> IDLE.
- IDLE:
  - Start=1 at edge E0 latches Op, OperandA, OperandB and DestReg, then enters CALC with counter=0.
  - For signed ops, operand magnitudes and result sign are computed at latch time. Later input changes are ignored.
- CALC:
  - Each edge performs one step and increments the counter.
  - After edge E32 (counter wraps 31->0), the state moves to FINISH.
- FINISH:
  - Lasts one cycle: Done=1, Busy=1, Result final, ResultReg=latched rd.
  - The next edge returns to IDLE, with Done=0 and Busy=0.
  - Result and ResultReg hold their values until the next Done.
- Latency: Done is high in the cycle after E32, i.e. 33 cycles from acceptance to the end of Done. Minimum Start-to-Start spacing is 34 cycles.
- Start while Busy=1, including during FINISH, is ignored and not queued.
- Multiply:
  - 64-bit unsigned shift-add on magnitudes, followed by two's-complement negation when the sign flag is set.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
  - MULHSU treats A as signed and B as unsigned.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = signA XOR signB; remainder sign = signA.
- Special cases (RISC-V defined, no trap):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; the matching REM returns 0.
- DestReg=0 still executes and pulses Done. The register file discards writes to x0.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Divisor-zero, signed-overflow, and multiply-with-either-operand-zero cases skip CALC.
  - The state goes IDLE->FINISH at E0+1, so Done is high in the cycle after E0+1 (2 cycles total). Results are identical to the full path.
- Undefined: every operation takes the full 33-cycle path, with identical results.

Decomposition:
- Package muldiv_pkg holds:
  - the Op funct3 localparams (OP_MUL..OP_REMU);
  - the state encoding (ST_IDLE, ST_CALC, ST_FINISH);
  - an is_div helper (Op[2]) and an is_signed-operand helper per op.
- Sub-module muldiv_step: a combinational single iteration, taking the mode, accumulator and remainder, and the shifted operand, and producing next accumulator/remainder and quotient bit. Instantiated once in muldiv_unit.

Test Plan:
- MUL A=7 B=0xFFFFFFFD, rd=5 -> Done 33 cycles after acceptance, Result=0xFFFFFFEB, ResultReg=5; Busy high for exactly 33 cycles.
- MULH A=B=0x80000000 -> Result=0x40000000. MULHU A=B=0xFFFFFFFF -> Result=0xFFFFFFFE. MULHSU A=0xFFFFFFFF B=2 -> Result=0xFFFFFFFF.
- DIVU 100/7 -> 14; REMU -> 2. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - With MULDIV_EARLY_OUT_EN, each completes with Done in the 2nd cycle after acceptance.
- Start pulsed at cycles 3 and 10 of a running op, with different operands -> ignored; the single Done carries the original result.
- rst_n low at cycle 15 of a DIV -> Busy, Done, Result and ResultReg go to 0 immediately. No Done follows. A new MUL 3*4 after reset returns 12.
